// File: rtl/serdes_frame_scheduler_pkg.sv
// Shared types and width helpers for the frame-atomic serializer scheduler.
package serdes_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } sched_state_e;

  // Width of a source index; a single source still needs one bit.
  function automatic int unsigned src_w(int unsigned n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

  function automatic int unsigned cnt_w(int unsigned n_samples);
    return (n_samples > 1) ? $clog2(n_samples) : 1;
  endfunction

endpackage

// File: rtl/serdes_frame_scheduler_if.sv
// Per-source sample ports plus the shared stream towards the serializer.
interface serdes_frame_scheduler_if
  import serdes_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SRC     = 4
);
  localparam int unsigned SRC_W = src_w(N_SRC);

  logic [BIT_WIDTH-1:0] recv_msg [N_SRC-1:0];
  logic [N_SRC-1:0]     recv_val;
  logic [N_SRC-1:0]     recv_rdy;
  logic [BIT_WIDTH-1:0] send_msg;
  logic                 send_val;
  logic                 send_rdy;
  logic [SRC_W-1:0]     send_src;
  logic                 send_last;

  modport master (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val, send_src, send_last
  );

  modport slave (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val, send_src, send_last
  );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_select
  import serdes_pkg::*;
#(
  parameter  int unsigned N_SRC = 4,
  localparam int unsigned SRC_W = src_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic             any,
  output logic [SRC_W-1:0] idx
);

  int unsigned j;

  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      j = (32'(ptr) + k) % N_SRC;
      if (!any && req[j[SRC_W-1:0]]) begin
        any = 1'b1;
        idx = SRC_W'(j);
      end
    end
  end

endmodule

// File: rtl/serdes_frame_scheduler.sv
// Grants one source at a time, passes exactly one N_SAMPLES-word frame, then
// rotates priority to the source after the one just served.
module serdes_frame_scheduler
  import serdes_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned N_SRC     = 4
) (
  input logic                      clk,
  input logic                      reset,
  serdes_frame_scheduler_if.master bus
);

  localparam int unsigned SRC_W = src_w(N_SRC);
  localparam int unsigned CNT_W = cnt_w(N_SAMPLES);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_SAMPLES - 1);
  localparam logic [SRC_W-1:0] LastSrc = SRC_W'(N_SRC - 1);

  sched_state_e     state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                 sel_any;
  logic [SRC_W-1:0]     sel_idx;
  logic [N_SRC-1:0]     recv_rdy;
  logic [BIT_WIDTH-1:0] send_msg;
  logic                 send_val;
  logic                 send_last;

  rr_priority_select #(
    .N_SRC(N_SRC)
  ) u_rr (
    .req(bus.recv_val),
    .ptr(ptr_q),
    .any(sel_any),
    .idx(sel_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    recv_rdy  = '0;
    send_val  = 1'b0;
    send_msg  = '0;
    send_last = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sel_any) begin
          grant_d = sel_idx;
          cnt_d   = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        // Pure pass-through: the granted source talks straight to the serializer.
        send_val           = bus.recv_val[grant_q];
        send_msg           = bus.recv_msg[grant_q];
        recv_rdy[grant_q]  = bus.send_rdy;
        send_last          = (cnt_q == LastCnt);
        if (send_val && bus.send_rdy) begin
          if (send_last) begin
            state_d = StIdle;
            ptr_d   = (grant_q == LastSrc) ? '0 : grant_q + SRC_W'(1);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.recv_rdy  = recv_rdy;
  assign bus.send_val  = send_val;
  assign bus.send_msg  = send_msg;
  assign bus.send_src  = grant_q;
  assign bus.send_last = send_last;

endmodule

// File: doc/serdes_frame_scheduler.md
# serdes_frame_scheduler

Frame-atomic round-robin scheduler that shares one serializer input stream among N_SRC sample sources. Each source presents frames of N_SAMPLES words on its own valid/ready port; the scheduler grants one source at a time, passes exactly one frame through, then rotates priority. It sits upstream of the shared Serializer/Deserializer link and tags every output word with its source index and an end-of-frame marker.

## Interface
- BIT_WIDTH, 32, width of one sample word
- N_SAMPLES, 8, words per frame, ≥1
- N_SRC, 4, number of requesting sources, ≥1
- SRC_W, $clog2(N_SRC) (min 1), width of the source index; derived, not overridden
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- recv_msg  in  N_SRC × BIT_WIDTH  per-source sample word (unpacked array [N_SRC-1:0])
- recv_val  in  N_SRC  per-source valid
- recv_rdy  out  N_SRC  per-source ready
- send_msg  out  BIT_WIDTH  word to serializer
- send_val  out  1  output valid
- send_rdy  in  1  serializer ready
- send_src  out  SRC_W  index of the source that owns the current word
- send_last  out  1  high on the final (N_SAMPLES-th) word of a frame

## Operation
- States: IDLE, BURST. Registers: state, grant (SRC_W), ptr (SRC_W), cnt ($clog2(N_SAMPLES), min 1).
- IDLE: all recv_rdy=0, send_val=0, send_msg=0, send_last=0, send_src=grant. If any recv_val set: grant ← first i with recv_val[i], searching ptr, ptr+1, … wrapping mod N_SRC; cnt ← 0; → BURST. Otherwise stay.
- BURST: send_val=recv_val[grant], send_msg=recv_msg[grant], send_src=grant, recv_rdy[grant]=send_rdy, all other recv_rdy=0. send_last=(cnt==N_SAMPLES-1).
- Transfer = send_val & send_rdy. On transfer with cnt<N_SAMPLES-1: cnt++. On transfer with cnt==N_SAMPLES-1: → IDLE, ptr ← (grant+1) mod N_SRC, cnt ← 0.
- Granted source dropping recv_val mid-frame: stall, grant held; no other source is served until frame completes.
- N_SRC=1: ptr stays 0. N_SAMPLES=1: send_last high on every BURST beat.

## Timing
- Reset values: state=IDLE, grant=0, ptr=0, cnt=0; hence recv_rdy=0, send_val=0, send_msg=0, send_src=0, send_last=0.
- Reset asserted mid-frame: partial frame abandoned, no completion; after release, arbitration restarts from ptr=0.
- Arbitration: 1 bubble cycle (IDLE) between frames; data path in BURST is combinational (0-cycle latency recv→send, send_rdy→recv_rdy).
- Peak throughput N_SAMPLES/(N_SAMPLES+1) words/cycle under continuous requests.
- recv_val sampled in IDLE only for arbitration; a source asserting in the same cycle as the grant decision competes normally.
- Fairness: each requesting source waits at most N_SRC-1 frames.

## Structure
- Shared package serdes_pkg: state enum typedef (IDLE, BURST), SRC_W / counter-width helper functions.
- One sub-module: rr_priority_select — combinational, inputs req[N_SRC], ptr; outputs any, idx. Scheduler instantiates it once.

## Test plan
(N_SRC=4, N_SAMPLES=8, BIT_WIDTH=32)
- Reset with all recv_val=1 → all outputs 0 during reset; first cycle after release IDLE, next cycle send_src=0 with send_val=1.
- Only source 2 valid, words 0x200..0x207, send_rdy=1 → 8 consecutive words 0x200..0x207, send_src=2, send_last only on 0x207, then 1 bubble cycle.
- All four sources valid continuously → frame order src 0,1,2,3,0; exactly 8 words each; one idle cycle between frames.
- send_rdy toggled 1/0 each cycle and source 1 dropping recv_val for 3 cycles mid-frame → no word lost/duplicated, other sources recv_rdy stay 0, frame completes with 8 words.
- Reset asserted after 3 words of source 3's frame → outputs 0 immediately; after release with sources 1 and 3 valid, source 1 granted first (ptr=0).
- N_SAMPLES=1, sources 0 and 3 valid → alternating single-word frames 0,3,0,3 with send_last=1 on each.
